// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer for a single-port SRAM BIST port.
// Issues one op per cycle and compares each read one cycle later, capturing the first miscompare.
module sram_march_bist_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BIST_EN,
  output logic                  BIST_MEN,
  output logic                  BIST_WEN,
  output logic                  BIST_REN,
  output logic [ADDR_WIDTH-1:0] BIST_ADDR,
  output logic [DATA_WIDTH-1:0] BIST_DIN,
  output logic [DATA_WIDTH-1:0] BIST_BM,
  input  logic [DATA_WIDTH-1:0] DOUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FAIL,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]            FAIL_ELEM,
  output logic [DATA_WIDTH-1:0] FAIL_DATA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [2:0]            LAST_ELEM = 3'd5;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  state_e                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    phase_q, phase_d;

  logic                    cmpValid_q, cmpValid_d;
  logic [DATA_WIDTH-1:0]   cmpExp_q, cmpExp_d;
  logic [ADDR_WIDTH-1:0]   cmpAddr_q, cmpAddr_d;
  logic [2:0]              cmpElem_q, cmpElem_d;

  logic                    fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]   failAddr_q, failAddr_d;
  logic [2:0]              failElem_q, failElem_d;
  logic [DATA_WIDTH-1:0]   failData_q, failData_d;

  logic                    running;
  logic                    startAccept;
  logic                    elemUp;
  logic                    nextUp;
  logic                    isWrite;
  logic                    opLast;
  logic                    addrLast;
  logic [DATA_WIDTH-1:0]   readPat;
  logic [DATA_WIDTH-1:0]   writePat;

  // Element decode: E3/E4 walk downward, E0 is write-only, E5 read-only.
  always_comb begin
    running     = (state_q == S_RUN);
    startAccept = START && ((state_q == S_IDLE) || (state_q == S_DONE));
    elemUp      = !((elem_q == 3'd3) || (elem_q == 3'd4));
    nextUp      = !((elem_q == 3'd2) || (elem_q == 3'd3));
    isWrite     = (elem_q == 3'd0) || phase_q;
    opLast      = isWrite || (elem_q == LAST_ELEM);
    addrLast    = elemUp ? (addr_q == ADDR_MAX) : (addr_q == '0);
    readPat     = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
    writePat    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  // The address only wraps when an element finishes; it reloads for the next element's direction.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          elem_d  = '0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_RUN: begin
        if (!opLast) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!addrLast) begin
            addr_d = elemUp ? addr_q + 1'b1 : addr_q - 1'b1;
          end else if (elem_q == LAST_ELEM) begin
            state_d = S_DRAIN;
            addr_d  = '0;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = nextUp ? '0 : ADDR_MAX;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BIST_MEN  = 1'b0;
    BIST_WEN  = 1'b0;
    BIST_REN  = 1'b0;
    BIST_ADDR = '0;
    BIST_DIN  = '0;
    BIST_BM   = '0;
    if (running) begin
      BIST_MEN  = 1'b1;
      BIST_WEN  = isWrite;
      BIST_REN  = !isWrite;
      BIST_ADDR = addr_q;
      if (isWrite) begin
        BIST_DIN = writePat;
        BIST_BM  = '1;
      end
    end
    BIST_EN   = running || (state_q == S_DRAIN);
    BUSY      = running || (state_q == S_DRAIN);
    DONE      = (state_q == S_DONE);
    FAIL      = fail_q;
    FAIL_ADDR = failAddr_q;
    FAIL_ELEM = failElem_q;
    FAIL_DATA = failData_q;
  end

  // A read issued now is checked against DOUT at the end of the following cycle.
  always_comb begin
    cmpValid_d = running && !isWrite;
    cmpExp_d   = readPat;
    cmpAddr_d  = addr_q;
    cmpElem_d  = elem_q;
    fail_d     = fail_q;
    failAddr_d = failAddr_q;
    failElem_d = failElem_q;
    failData_d = failData_q;
    if (startAccept) begin
      fail_d     = 1'b0;
      failAddr_d = '0;
      failElem_d = '0;
      failData_d = '0;
    end else if (cmpValid_q && (DOUT != cmpExp_q) && !fail_q) begin
      fail_d     = 1'b1;
      failAddr_d = cmpAddr_q;
      failElem_d = cmpElem_q;
      failData_d = DOUT ^ cmpExp_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cmpValid_q <= 1'b0;
      cmpExp_q   <= '0;
      cmpAddr_q  <= '0;
      cmpElem_q  <= '0;
      fail_q     <= 1'b0;
      failAddr_q <= '0;
      failElem_q <= '0;
      failData_q <= '0;
    end else begin
      cmpValid_q <= cmpValid_d;
      cmpExp_q   <= cmpExp_d;
      cmpAddr_q  <= cmpAddr_d;
      cmpElem_q  <= cmpElem_d;
      fail_q     <= fail_d;
      failAddr_q <= failAddr_d;
      failElem_q <= failElem_d;
      failData_q <= failData_d;
    end
  end

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl: a behavioural SRAM with one injectable stuck-at bit,
// plus an op list and first-failure prediction built directly from the March C- element table.
module tb_sram_march_bist_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int N     = 1 << AW;
  localparam int TOTAL = 10 * N;

  logic          CLK;
  logic          RST;
  logic          START;
  logic          BIST_EN;
  logic          BIST_MEN;
  logic          BIST_WEN;
  logic          BIST_REN;
  logic [AW-1:0] BIST_ADDR;
  logic [DW-1:0] BIST_DIN;
  logic [DW-1:0] BIST_BM;
  logic [DW-1:0] DOUT;
  logic          BUSY;
  logic          DONE;
  logic          FAIL;
  logic [AW-1:0] FAIL_ADDR;
  logic [2:0]    FAIL_ELEM;
  logic [DW-1:0] FAIL_DATA;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [N];
  logic          faultEn = 1'b0;
  int            faultAddr = 0;
  int            faultBit = 0;
  logic          faultVal = 1'b0;

  logic [AW-1:0] opAddr [TOTAL];
  bit            opWrite [TOTAL];
  logic [DW-1:0] opData [TOTAL];
  int            opElem [TOTAL];

  sram_march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .BIST_EN(BIST_EN), .BIST_MEN(BIST_MEN), .BIST_WEN(BIST_WEN), .BIST_REN(BIST_REN),
    .BIST_ADDR(BIST_ADDR), .BIST_DIN(BIST_DIN), .BIST_BM(BIST_BM), .DOUT(DOUT),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
    .FAIL_ADDR(FAIL_ADDR), .FAIL_ELEM(FAIL_ELEM), .FAIL_DATA(FAIL_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] faultView(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (faultEn && (int'(a) == faultAddr)) r[faultBit] = faultVal;
    return r;
  endfunction

  // One-cycle read latency SRAM with per-bit write mask.
  always @(posedge CLK) begin
    if (BIST_MEN && BIST_WEN) mem[BIST_ADDR] <= (mem[BIST_ADDR] & ~BIST_BM) | (BIST_DIN & BIST_BM);
    if (BIST_MEN && BIST_REN) DOUT <= faultView(BIST_ADDR, mem[BIST_ADDR]);
  end

  task automatic buildModel();
    int idx;
    int a;
    idx = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? (N - 1 - i) : i;
        if (e != 0) begin
          opAddr[idx] = AW'(a); opWrite[idx] = 1'b0; opElem[idx] = e;
          opData[idx] = (e == 2 || e == 4) ? {DW{1'b1}} : {DW{1'b0}};
          idx++;
        end
        if (e != 5) begin
          opAddr[idx] = AW'(a); opWrite[idx] = 1'b1; opElem[idx] = e;
          opData[idx] = (e == 1 || e == 3) ? {DW{1'b1}} : {DW{1'b0}};
          idx++;
        end
      end
    end
  endtask

  task automatic predictFault(output logic ef, output int eAddr, output int eElem, output logic [DW-1:0] eData);
    logic [DW-1:0] act;
    ef = 1'b0; eAddr = 0; eElem = 0; eData = '0;
    for (int i = 0; i < TOTAL; i++) begin
      if (!opWrite[i] && int'(opAddr[i]) == faultAddr && !ef) begin
        act = opData[i];
        act[faultBit] = faultVal;
        if (act != opData[i]) begin
          ef = 1'b1; eAddr = faultAddr; eElem = opElem[i]; eData = act ^ opData[i];
        end
      end
    end
  endtask

  // Pulses START and follows the run cycle by cycle; only gathers observations.
  task automatic runObserve(input int ig1, input int ig2, output int badOps, output int firstBad,
                            output int doneAt, output int ctlBad, output logic [1:0] statusAt0);
    bit opBad;
    badOps = 0; firstBad = -1; doneAt = -1; ctlBad = 0; statusAt0 = '0;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int c = 0; c < TOTAL + 20 && doneAt < 0; c++) begin
      if (c == ig1 || c == ig2) START = 1'b1;
      @(negedge CLK);
      if (c == 0) statusAt0 = {DONE, FAIL};
      if (c < TOTAL) begin
        opBad = (BIST_MEN !== 1'b1) || (BIST_WEN !== opWrite[c]) || (BIST_REN !== !opWrite[c]) ||
                (BIST_ADDR !== opAddr[c]) ||
                (opWrite[c] && ((BIST_DIN !== opData[c]) || (BIST_BM !== {DW{1'b1}})));
        if (opBad) begin badOps++; if (firstBad < 0) firstBad = c; end
      end else if (c == TOTAL && BIST_MEN !== 1'b0) begin
        badOps++; if (firstBad < 0) firstBad = c;
      end
      if (c <= TOTAL) begin
        if (BUSY !== 1'b1 || BIST_EN !== 1'b1 || DONE !== 1'b0) ctlBad++;
      end else if (DONE === 1'b1) begin
        doneAt = c;
        if (BUSY !== 1'b0 || BIST_EN !== 1'b0 || {BIST_MEN, BIST_WEN, BIST_REN} !== 3'b000 ||
            BIST_ADDR !== '0 || BIST_DIN !== '0 || BIST_BM !== '0) ctlBad++;
      end else begin
        ctlBad++;
      end
      @(posedge CLK); #1;
      START = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BUSY, DONE, FAIL} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b want 0000000", {BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BUSY, DONE, FAIL});
    end
    checks++;
    if ({BIST_ADDR, BIST_DIN, BIST_BM} !== '0) begin
      errors++; $display("[TB] FAIL reset_bus: addr=%h din=%h bm=%h want all 0", BIST_ADDR, BIST_DIN, BIST_BM);
    end
    checks++;
    if ({FAIL_ADDR, FAIL_ELEM, FAIL_DATA} !== '0) begin
      errors++; $display("[TB] FAIL reset_capture: addr=%h elem=%0d data=%h want 0", FAIL_ADDR, FAIL_ELEM, FAIL_DATA);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle_busy: got %b want 0", BUSY);
    end
  endtask

  task automatic test_rst_start_together();
    RST = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0 || BIST_EN !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_start_busy: busy=%b en=%b want 0 0", BUSY, BIST_EN);
    end
    RST = 1'b0; START = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_start_after: busy=%b done=%b want 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_clean_run();
    int badOps, firstBad, doneAt, ctlBad;
    logic [1:0] s0;
    faultEn = 1'b0;
    runObserve(-1, -1, badOps, firstBad, doneAt, ctlBad, s0);
    checks++;
    if (badOps != 0) begin
      errors++; $display("[TB] FAIL clean_ops: bad=%0d first_cycle=%0d want 0", badOps, firstBad);
    end
    checks++;
    if (doneAt != TOTAL + 1) begin
      errors++; $display("[TB] FAIL clean_done_time: got %0d want %0d", doneAt, TOTAL + 1);
    end
    checks++;
    if (ctlBad != 0) begin
      errors++; $display("[TB] FAIL clean_ctrl: bad cycles=%0d want 0", ctlBad);
    end
    checks++;
    if (FAIL !== 1'b0 || FAIL_DATA !== '0) begin
      errors++; $display("[TB] FAIL clean_flag: flag=%b data=%h want 0 0", FAIL, FAIL_DATA);
    end
  endtask

  task automatic test_stuck_bit3();
    int badOps, firstBad, doneAt, ctlBad;
    logic [1:0] s0;
    faultEn = 1'b1; faultAddr = 'h155; faultBit = 3; faultVal = 1'b1;
    runObserve(-1, -1, badOps, firstBad, doneAt, ctlBad, s0);
    checks++;
    if (FAIL !== 1'b1 || FAIL_ADDR !== 10'h155 || FAIL_ELEM !== 3'd1 || FAIL_DATA !== 16'h0008) begin
      errors++; $display("[TB] FAIL sa1_capture: flag=%b addr=%h elem=%0d data=%h want 1 155 1 0008",
                         FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_DATA);
    end
    checks++;
    if (doneAt != TOTAL + 1 || badOps != 0) begin
      errors++; $display("[TB] FAIL sa1_run: done=%0d bad=%0d want %0d 0", doneAt, badOps, TOTAL + 1);
    end
  endtask

  task automatic test_start_in_done();
    int badOps, firstBad, doneAt, ctlBad, eAddr, eElem;
    logic [1:0] s0;
    logic ef;
    logic [DW-1:0] eData;
    faultEn = 1'b1;
    faultAddr = $urandom_range(0, N - 1);
    faultBit = $urandom_range(0, DW - 1);
    faultVal = 1'($urandom_range(0, 1));
    predictFault(ef, eAddr, eElem, eData);
    $display("[TB] random stuck-at: addr=%h bit=%0d val=%b", faultAddr, faultBit, faultVal);
    runObserve(-1, -1, badOps, firstBad, doneAt, ctlBad, s0);
    checks++;
    if (s0 !== 2'b00) begin
      errors++; $display("[TB] FAIL rerun_clear: done,flag at first cycle=%b want 00", s0);
    end
    checks++;
    if (FAIL !== ef || int'(FAIL_ADDR) != eAddr || int'(FAIL_ELEM) != eElem || FAIL_DATA !== eData) begin
      errors++; $display("[TB] FAIL rand_capture: flag=%b addr=%h elem=%0d data=%h want %b %h %0d %h",
                         FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_DATA, ef, eAddr, eElem, eData);
    end
    checks++;
    if (doneAt != TOTAL + 1 || badOps != 0 || ctlBad != 0) begin
      errors++; $display("[TB] FAIL rand_run: done=%0d bad=%0d ctl=%0d want %0d 0 0", doneAt, badOps, ctlBad, TOTAL + 1);
    end
  endtask

  task automatic test_start_while_busy();
    int badOps, firstBad, doneAt, ctlBad;
    logic [1:0] s0;
    faultEn = 1'b0;
    runObserve(10, 9000, badOps, firstBad, doneAt, ctlBad, s0);
    checks++;
    if (doneAt != TOTAL + 1 || badOps != 0) begin
      errors++; $display("[TB] FAIL busy_start_ignored: done=%0d bad=%0d first=%0d want %0d 0",
                         doneAt, badOps, firstBad, TOTAL + 1);
    end
    checks++;
    if (FAIL !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_start_flag: got %b want 0", FAIL);
    end
  endtask

  task automatic test_reset_mid_run();
    int badOps, firstBad, doneAt, ctlBad;
    logic [1:0] s0;
    faultEn = 1'b1; faultAddr = 0; faultBit = $urandom_range(0, DW - 1); faultVal = 1'b1;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5000) @(posedge CLK);
    #1;
    checks++;
    if (FAIL !== 1'b1 || BUSY !== 1'b1) begin
      errors++; $display("[TB] FAIL midrun_pre: flag=%b busy=%b want 1 1", FAIL, BUSY);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BUSY, DONE, FAIL} !== 7'b0 ||
        {BIST_ADDR, BIST_DIN, BIST_BM, FAIL_ADDR, FAIL_ELEM, FAIL_DATA} !== '0) begin
      errors++; $display("[TB] FAIL midrun_reset: ctrl=%b addr=%h din=%h fail_addr=%h want all 0",
                         {BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BUSY, DONE, FAIL}, BIST_ADDR, BIST_DIN, FAIL_ADDR);
    end
    RST = 1'b0;
    faultEn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b0 || FAIL !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_idle: busy=%b flag=%b want 0 0", BUSY, FAIL);
    end
    runObserve(-1, -1, badOps, firstBad, doneAt, ctlBad, s0);
    checks++;
    if (doneAt != TOTAL + 1 || badOps != 0 || ctlBad != 0 || FAIL !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_rerun: done=%0d bad=%0d ctl=%0d flag=%b want %0d 0 0 0",
                         doneAt, badOps, ctlBad, FAIL, TOTAL + 1);
    end
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1;
    START = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    buildModel();
    @(posedge CLK); #1;
    test_reset();
    test_rst_start_together();
    test_clean_run();
    test_stuck_bit3();
    test_start_in_done();
    test_start_while_busy();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_march_bist_ctrl.md
SRAM_MARCH_BIST_CTRL -- requirements
Module: sram_march_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SRAM data and bit-mask width.
REQ-003 SHALL have port CLK, input, 1, single clock; shared with the SRAM BIST_CLK pin; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port START, input, 1, one-cycle request to run the test.
REQ-006 SHALL have port BIST_EN, output, 1, selects the SRAM BIST port.
REQ-007 SHALL have ports BIST_MEN, BIST_WEN and BIST_REN, each output, 1, SRAM BIST memory enable, write enable and read enable.
REQ-008 SHALL have port BIST_ADDR, output, ADDR_WIDTH, SRAM BIST address.
REQ-009 SHALL have ports BIST_DIN and BIST_BM, each output, DATA_WIDTH, SRAM BIST write data and bit mask.
REQ-010 SHALL have port DOUT, input, DATA_WIDTH, SRAM read data (same-side DOUT pin).
REQ-011 SHALL have port BUSY, output, 1, test in progress.
REQ-012 SHALL have port DONE, output, 1, test finished; held until the next START or reset.
REQ-013 SHALL have port FAIL, output, 1, sticky flag: at least one read miscompare.
REQ-014 SHALL have ports FAIL_ADDR, output, ADDR_WIDTH, and FAIL_ELEM, output, 3, address and March element index of the first miscompare.
REQ-015 SHALL have port FAIL_DATA, output, DATA_WIDTH, XOR of expected and actual data at the first miscompare.

Function
REQ-016 SHALL run March C- in element order:
- E0 up(w0)
- E1 up(r0,w1)
- E2 up(r1,w0)
- E3 down(r0,w1)
- E4 down(r1,w0)
- E5 up(r0)
Up runs address 0 to 2^ADDR_WIDTH-1; down runs 2^ADDR_WIDTH-1 to 0. Data "0" is all-zeros and "1" is all-ones.
REQ-017 SHALL use FSM states IDLE, RUN, DRAIN and DONE.
- IDLE to RUN on START.
- RUN to DRAIN after the last E5 op.
- DRAIN to DONE after one cycle.
- DONE to RUN on START.
REQ-018 SHALL issue exactly one op per RUN cycle. Two-op elements SHALL issue the read then the write to the same address on consecutive cycles, then advance the address. There SHALL be no idle cycles between elements.
REQ-019 SHALL, in a RUN write cycle, drive MEN=1, WEN=1, REN=0, DIN=pattern, BM=all-ones.
REQ-020 SHALL, in a RUN read cycle, drive MEN=1, WEN=0, REN=1.
REQ-021 SHALL, outside RUN, drive MEN=WEN=REN=0 and ADDR=DIN=BM=0.
REQ-022 SHALL hold BIST_EN=1 in RUN and DRAIN, and 0 otherwise.
REQ-023 SHALL treat read latency as 1 cycle: a read issued in cycle t is compared against DOUT sampled at the end of cycle t+1. SHALL register the expected data, address and element alongside the compare.
REQ-024 SHALL, on the first miscompare, set FAIL and capture FAIL_ADDR, FAIL_ELEM and FAIL_DATA. Later miscompares SHALL NOT update the capture. The test SHALL run to completion regardless of miscompares.
REQ-025 SHALL compare the final E5 read during DRAIN.
REQ-026 SHALL take 10*2^ADDR_WIDTH RUN cycles in total (10240 at default).
REQ-027 SHALL hold BUSY=1 in RUN and DRAIN.
REQ-028 SHALL assert DONE from the cycle after DRAIN.
REQ-029 SHALL ignore START while BUSY.
REQ-030 SHALL, on START in IDLE or DONE, clear DONE, FAIL, FAIL_ADDR, FAIL_ELEM and FAIL_DATA in the same edge that enters RUN.
REQ-031 SHALL wrap the address counter only at element boundaries. Wrap at the last address of an up element (and at 0 of a down element) SHALL reload for the next element's direction.

Reset
REQ-032 SHALL, on RST=1 at a clock edge, enter IDLE from any state, including mid-RUN.
REQ-033 SHALL reset every output to 0: BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM, BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_DATA.
REQ-034 SHALL discard any pending compare on reset.
REQ-035 SHALL give RST priority over START when both are high.

Verification
REQ-036 SHALL pass fault-free SRAM at defaults: START pulse at edge k -> BUSY=1 from k+1; first op ADDR=0x000, WEN=1, DIN=0x0000; DONE=1 from edge k+10242; FAIL=0.
REQ-037 SHALL check the sequence: E3 first op has ADDR=0x3FF, REN=1; the E5 last op has ADDR=0x3FF, REN=1; there are no gaps between ops.
REQ-038 SHALL detect stuck-at-1 on bit 3 at 0x155 -> FAIL=1, FAIL_ADDR=0x155, FAIL_ELEM=1, FAIL_DATA=0x0008, DONE still at k+10242.
REQ-039 SHALL recover from RST asserted at RUN cycle 5000 -> all outputs 0 next edge. A later START SHALL then run a full clean pass.
REQ-040 SHALL ignore START pulses at RUN cycles 10 and 9000 (no restart, DONE timing unchanged). START while DONE SHALL clear FAIL/DONE and rerun.
REQ-041 SHALL hold simultaneous RST and START in IDLE with BUSY=0.
